// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, derivation helpers and pixel/control types for VGA scan-out
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int fb_w(input int active, input int scale);
        return active / scale;
    endfunction

    // Counter width able to hold 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
        logic vblank;
        logic fstart;
    } vid_ctl_t;

    localparam vid_ctl_t CTL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, vblank: 1'b0, fstart: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - horizontal/vertical counters with raw sync, active and wrap strobes
//   clock_i, reset_i        : pixel clock, synchronous active-high reset
//   hcnt_o, vcnt_o          : current counter position
//   active_o, vblank_o      : visible-region flag, line >= V_ACTIVE flag
//   hs_n_o, vs_n_o          : raw active-low syncs in the counter domain
//   line_wrap_o             : last clock of a line
//   frame_wrap_o            : last clock of a frame
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = cnt_w(H_TOTAL),
    localparam int VW      = cnt_w(V_TOTAL)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    output logic [HW-1:0] hcnt_o,
    output logic [VW-1:0] vcnt_o,
    output logic          active_o,
    output logic          vblank_o,
    output logic          hs_n_o,
    output logic          vs_n_o,
    output logic          line_wrap_o,
    output logic          frame_wrap_o
);

    logic [HW-1:0] hcnt_q;
    logic [VW-1:0] vcnt_q;
    logic          line_end;
    logic          frame_end;

    assign line_end  = (hcnt_q == HW'(H_TOTAL - 1));
    assign frame_end = line_end && (vcnt_q == VW'(V_TOTAL - 1));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (line_end) begin
            hcnt_q <= '0;
            vcnt_q <= frame_end ? '0 : vcnt_q + VW'(1);
        end else begin
            hcnt_q <= hcnt_q + HW'(1);
        end
    end

    assign hcnt_o       = hcnt_q;
    assign vcnt_o       = vcnt_q;
    assign active_o     = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
    assign vblank_o     = (vcnt_q >= VW'(V_ACTIVE));
    assign hs_n_o       = !((hcnt_q >= HW'(H_ACTIVE + H_FP)) && (hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_n_o       = !((vcnt_q >= VW'(V_ACTIVE + V_FP)) && (vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign line_wrap_o  = line_end;
    assign frame_wrap_o = frame_end;

endmodule

// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - VGA scan-out: RAM port-B addressing, per-frame base latch, latency realignment, RGB444 unpack
//   clock, reset            : pixel clock, synchronous active-high reset
//   fb_base                 : framebuffer base word address, taken at the frame boundary
//   address_vga, q_vga      : RAM port-B read address (registered) and read data
//   VGA_R/G/B, VGA_HS/VS    : pixel colour and active-low syncs
//   vblank, frame_start     : output-aligned vertical blank and pixel (0,0) pulse
module vram_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SCALE    = 4,
    parameter int RD_LAT   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] fb_base,
    output logic [15:0] address_vga,
    input  logic [15:0] q_vga,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        vblank,
    output logic        frame_start
);

    localparam int HW   = cnt_w(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW   = cnt_w(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int FB_W = fb_w(H_ACTIVE, SCALE);
    localparam int PIPE = RD_LAT + 2;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          active, vblank_raw, hs_n, vs_n, line_wrap, frame_wrap;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clock_i      (clock),
        .reset_i      (reset),
        .hcnt_o       (hcnt),
        .vcnt_o       (vcnt),
        .active_o     (active),
        .vblank_o     (vblank_raw),
        .hs_n_o       (hs_n),
        .vs_n_o       (vs_n),
        .line_wrap_o  (line_wrap),
        .frame_wrap_o (frame_wrap)
    );

    logic [15:0]   line_base_q;
    logic [15:0]   active_base_q;
    logic [15:0]   addr_q;
    logic [HW-1:0] x_word_q;
    logic          x_tick;
    logic          row_last;

    // SCALE is a power of two, so "last pixel of a replicated group" is a low-bit mask test.
    assign x_tick   = active && ((hcnt & HW'(SCALE - 1)) == HW'(SCALE - 1));
    assign row_last = ((vcnt & VW'(SCALE - 1)) == VW'(SCALE - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            line_base_q   <= '0;
            active_base_q <= '0;
            addr_q        <= '0;
            x_word_q      <= '0;
        end else begin
            if (active) begin
                addr_q <= line_base_q + 16'(x_word_q);
            end

            if (line_wrap) begin
                x_word_q <= '0;
            end else if (x_tick) begin
                x_word_q <= x_word_q + HW'(1);
            end

            if (frame_wrap) begin
                active_base_q <= fb_base;
                line_base_q   <= fb_base;
            end else if (line_wrap && (vcnt == VW'(V_ACTIVE - 1))) begin
                // Leaving the visible lines: park the line pointer on this frame's base.
                line_base_q <= active_base_q;
            end else if (line_wrap && (vcnt < VW'(V_ACTIVE)) && row_last) begin
                line_base_q <= line_base_q + 16'(FB_W);
            end
        end
    end

    vid_ctl_t ctl_raw;
    vid_ctl_t pipe_q [PIPE];
    rgb444_t  rgb_q;
    logic     unused_q_hi;

    assign ctl_raw = '{
        active: active,
        hs_n:   hs_n,
        vs_n:   vs_n,
        vblank: vblank_raw,
        fstart: (hcnt == '0) && (vcnt == '0)
    };

    assign unused_q_hi = ^q_vga[15:12];

    // pipe_q[RD_LAT] lines up with q_vga for the same pixel; the last stage
    // lines up with the RGB register one clock later.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe_q[i] <= CTL_IDLE;
            end
            rgb_q <= '0;
        end else begin
            pipe_q[0] <= ctl_raw;
            for (int i = 1; i < PIPE; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            rgb_q <= pipe_q[RD_LAT].active ? rgb444_t'(q_vga[11:0]) : '0;
        end
    end

    assign address_vga = addr_q;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign VGA_HS      = pipe_q[PIPE-1].hs_n;
    assign VGA_VS      = pipe_q[PIPE-1].vs_n;
    assign vblank      = pipe_q[PIPE-1].vblank;
    assign frame_start = pipe_q[PIPE-1].fstart;

endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - self-checking bench for vram_scanout on a reduced 24x12 raster
module tb_vram_scanout;

    localparam int HA = 16, HF = 2, HSY = 4, HB = 2;
    localparam int VA = 8,  VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int SC = 4;
    localparam int FBW = HA / SC;
    localparam int RL = 2;
    localparam int FRAME = HT * VT;
    localparam int TR_N = 1200;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] fb_base;
    logic [15:0] address_vga;
    logic [15:0] q_vga;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, vblank, frame_start;

    vram_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .SCALE(SC), .RD_LAT(RL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fb_base     (fb_base),
        .address_vga (address_vga),
        .q_vga       (q_vga),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:65535];
    logic [15:0] ram_a_q;

    // Port-B model: address register then data register, two clocks total.
    always @(posedge clock) begin
        ram_a_q <= address_vga;
        q_vga   <= mem[ram_a_q];
    end

    logic [15:0] addr_tr [0:TR_N];
    logic [11:0] rgb_tr  [0:TR_N];
    logic [3:0]  ctl_tr  [0:TR_N];
    logic [15:0] base_tab [0:4];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          kind;
        string       name;
        int          n;
        logic [15:0] val;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int kind, input string name, input int n, input logic [15:0] val, input logic [3:0] flags);
        vec_t v;
        v.kind = kind; v.name = name; v.n = n; v.val = val; v.flags = flags;
        vecs.push_back(v);
    endtask

    function automatic logic [15:0] exp_addr(input int p);
        int f, r, h, v;
        f = p / FRAME;
        r = p % FRAME;
        v = r / HT;
        h = r % HT;
        if (v >= VA) begin
            v = VA - 1;
            h = HA - 1;
        end else if (h >= HA) begin
            h = HA - 1;
        end
        return base_tab[f] + 16'((v / SC) * FBW + h / SC);
    endfunction

    function automatic logic [15:0] exp_out(input int p);
        int r, h, v;
        logic [15:0] a;
        logic [11:0] rgb;
        if (p < 0) return {12'h000, 4'b1100};
        r = p % FRAME;
        v = r / HT;
        h = r % HT;
        rgb = 12'h000;
        if (h < HA && v < VA) begin
            a = exp_addr(p);
            rgb = mem[a][11:0];
        end
        return {rgb, !(h >= HA + HF && h < HA + HF + HSY), !(v >= VA + VF && v < VA + VF + VSY),
                v >= VA, h == 0 && v == 0};
    endfunction

    task automatic capture(input int ncyc, input bit sched);
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clock);
            @(negedge clock);
            addr_tr[n] = address_vga;
            rgb_tr[n]  = {VGA_R, VGA_G, VGA_B};
            ctl_tr[n]  = {VGA_HS, VGA_VS, vblank, frame_start};
            if (sched && n == FRAME + 100)     fb_base = 16'h5000;
            if (sched && n == 2 * FRAME + 100) fb_base = 16'hFFFE;
        end
    endtask

    task automatic sweep(input string tag, input int nmax);
        for (int n = 1; n <= nmax; n++) begin
            check($sformatf("%s n=%0d", tag, n),
                  {addr_tr[n], rgb_tr[n], ctl_tr[n]},
                  {exp_addr(n - 1), exp_out(n - 4)});
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = {4'hC, 12'(i) ^ 12'h5A5};
        end
        mem[16'h1000] = 16'h0ABC;

        // Trace index n holds the address for counter position n-1 and the outputs for position n-4.
        add(0, "f0_px00",      1,   16'h0000, 4'h0);
        add(0, "f1_px00",      289, 16'h1000, 4'h0);
        add(0, "f1_h3",        292, 16'h1000, 4'h0);
        add(0, "f1_h4",        293, 16'h1001, 4'h0);
        add(0, "f1_h15",       304, 16'h1003, 4'h0);
        add(0, "f1_hblank",    305, 16'h1003, 4'h0);
        add(0, "f1_v3",        361, 16'h1000, 4'h0);
        add(0, "f1_v4",        385, 16'h1004, 4'h0);
        add(0, "f1_flip_v7",   472, 16'h1007, 4'h0);
        add(0, "f1_vbl_hold",  481, 16'h1007, 4'h0);
        add(0, "f2_px00",      577, 16'h5000, 4'h0);
        add(0, "f3_px00",      865, 16'hFFFE, 4'h0);
        add(0, "f3_h4",        869, 16'hFFFF, 4'h0);
        add(0, "f3_wrap",      873, 16'h0000, 4'h0);
        add(0, "f3_v4",        961, 16'h0002, 4'h0);
        add(1, "o_f0_last",    291, 16'h0000, 4'b1110);
        add(1, "o_f1_first",   292, 16'h0ABC, 4'b1101);
        add(1, "o_f1_px1",     293, 16'h0ABC, 4'b1100);
        add(1, "o_f1_px4",     296, 16'h05A4, 4'b1100);
        add(1, "o_f1_hblank",  308, 16'h0000, 4'b1100);
        add(1, "o_hs_first",   310, 16'h0000, 4'b0100);
        add(1, "o_hs_last",    313, 16'h0000, 4'b0100);
        add(1, "o_hs_off",     314, 16'h0000, 4'b1100);
        add(1, "o_vb_first",   484, 16'h0000, 4'b1110);
        add(1, "o_vs_first",   508, 16'h0000, 4'b1010);
        add(1, "o_vs_last",    555, 16'h0000, 4'b1010);
        add(1, "o_vs_off",     556, 16'h0000, 4'b1110);
        add(1, "o_f2_first",   580, 16'h05A5, 4'b1101);
        add(1, "o_f3_h4",      872, 16'h0A5A, 4'b1100);
        add(1, "o_f3_wrap",    876, 16'h05A5, 4'b1100);

        reset   = 1'b1;
        fb_base = 16'h1000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state", {address_vga, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, vblank, frame_start},
              {16'h0000, 12'h000, 4'b1100});
        reset = 1'b0;

        capture(4 * FRAME + 8, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].kind == 0)
                check(vecs[i].name, {16'h0, addr_tr[vecs[i].n]}, {16'h0, vecs[i].val});
            else
                check(vecs[i].name, {16'h0, rgb_tr[vecs[i].n], ctl_tr[vecs[i].n]},
                      {16'h0, vecs[i].val[11:0], vecs[i].flags});
        end

        base_tab[0] = 16'h0000;
        base_tab[1] = 16'h1000;
        base_tab[2] = 16'h5000;
        base_tab[3] = 16'hFFFE;
        base_tab[4] = 16'hFFFE;
        sweep("sweepA", 4 * FRAME + 8);

        // One-clock reset in the middle of an active line.
        check("pre_reset_addr", {16'h0, address_vga}, {16'h0, 16'hFFFF});
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midframe_reset", {address_vga, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, vblank, frame_start},
              {16'h0000, 12'h000, 4'b1100});
        reset = 1'b0;

        capture(2 * FRAME + 8, 1'b0);
        check("restart_px00_addr", {16'h0, addr_tr[1]}, {16'h0, 16'h0000});
        check("restart_fstart", {28'h0, ctl_tr[4]}, {28'h0, 4'b1101});
        base_tab[0] = 16'h0000;
        base_tab[1] = 16'hFFFE;
        base_tab[2] = 16'hFFFE;
        sweep("sweepB", 2 * FRAME + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
